// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU control codes, operand/writeback
// select encodings and the decoded-instruction bundle carried through the pipe.
package rv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Codes 0..7 are reserved for branch compares ({3'b0, funct3})
    localparam logic [5:0] ALU_ADD   = 6'd8;
    localparam logic [5:0] ALU_SUB   = 6'd9;
    localparam logic [5:0] ALU_SLL   = 6'd10;
    localparam logic [5:0] ALU_SLT   = 6'd11;
    localparam logic [5:0] ALU_SLTU  = 6'd12;
    localparam logic [5:0] ALU_XOR   = 6'd13;
    localparam logic [5:0] ALU_SRL   = 6'd14;
    localparam logic [5:0] ALU_SRA   = 6'd15;
    localparam logic [5:0] ALU_OR    = 6'd16;
    localparam logic [5:0] ALU_AND   = 6'd17;
    localparam logic [5:0] ALU_PASSB = 6'd18;

    localparam logic [1:0] OPA_RS1  = 2'b00;
    localparam logic [1:0] OPA_PC   = 2'b01;
    localparam logic [1:0] OPA_PC4  = 2'b10;
    localparam logic [1:0] OPA_ZERO = 2'b11;
    localparam logic [1:0] OPB_RS2  = 2'b00;
    localparam logic [1:0] OPB_IMM  = 2'b01;
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [5:0]  alu_ctrl;
        logic [1:0]  op_a_sel;
        logic [1:0]  op_b_sel;
        logic [1:0]  wb_sel;
        logic [2:0]  mem_size;
        logic        wen;
        logic        mem_wen;
        logic        branch_op;
        logic        jump;
        logic        illegal;
    } decode_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [5:0] alu_code(input logic [2:0] f3, input logic alt);
        logic [5:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I decoder: raw fields, immediate, ALU control,
// operand/writeback selects and illegal-instruction detection.
module decode_comb
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    decode_t     raw_s;

    assign f3_s    = instr[14:12];
    assign f7_s    = instr[31:25];
    assign imm_i_s = {{20{instr[31]}}, instr[31:20]};
    assign imm_s_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u_s = {instr[31:12], 12'b0};
    assign imm_j_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Per-opcode controls before illegal/rd==0 gating
    always_comb begin
        raw_s          = '0;
        raw_s.opcode   = instr[6:0];
        raw_s.rs1      = instr[19:15];
        raw_s.rs2      = instr[24:20];
        raw_s.rd       = instr[11:7];
        raw_s.funct3   = f3_s;
        raw_s.funct7   = f7_s;
        raw_s.alu_ctrl = ALU_ADD;
        case (instr[6:0])
            OP_REG: begin
                raw_s.wen      = 1'b1;
                raw_s.alu_ctrl = alu_code(f3_s, f7_s[5]);
                if (f7_s == 7'h00) begin
                    raw_s.illegal = 1'b0;
                end else if (f7_s == 7'h20) begin
                    raw_s.illegal = (f3_s != 3'b000) && (f3_s != 3'b101);
                end else begin
                    raw_s.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                raw_s.wen      = 1'b1;
                raw_s.op_b_sel = OPB_IMM;
                raw_s.imm      = imm_i_s;
                raw_s.alu_ctrl = alu_code(f3_s, (f3_s == 3'b101) && f7_s[5]);
                if ((f3_s != 3'b001) && (f3_s != 3'b101)) begin
                    raw_s.illegal = 1'b0;
                end else if (f7_s == 7'h00) begin
                    raw_s.illegal = 1'b0;
                end else if (f7_s == 7'h20) begin
                    raw_s.illegal = (f3_s != 3'b101);
                end else begin
                    raw_s.illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                raw_s.wen      = 1'b1;
                raw_s.wb_sel   = WB_MEM;
                raw_s.op_b_sel = OPB_IMM;
                raw_s.imm      = imm_i_s;
                raw_s.mem_size = f3_s;
                raw_s.illegal  = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
            end
            OP_STORE: begin
                raw_s.mem_wen  = 1'b1;
                raw_s.op_b_sel = OPB_IMM;
                raw_s.imm      = imm_s_s;
                raw_s.mem_size = f3_s;
                raw_s.illegal  = (f3_s > 3'b010);
            end
            OP_BRANCH: begin
                raw_s.branch_op = 1'b1;
                raw_s.alu_ctrl  = {3'b000, f3_s};
                raw_s.imm       = imm_b_s;
                raw_s.illegal   = (f3_s == 3'b010) || (f3_s == 3'b011);
            end
            OP_JAL: begin
                raw_s.jump     = 1'b1;
                raw_s.wen      = 1'b1;
                raw_s.wb_sel   = WB_PC4;
                raw_s.op_a_sel = OPA_PC;
                raw_s.op_b_sel = OPB_IMM;
                raw_s.imm      = imm_j_s;
            end
            OP_JALR: begin
                raw_s.jump     = 1'b1;
                raw_s.wen      = 1'b1;
                raw_s.wb_sel   = WB_PC4;
                raw_s.op_b_sel = OPB_IMM;
                raw_s.imm      = imm_i_s;
                raw_s.illegal  = (f3_s != 3'b000);
            end
            // U-type results are written back like any ALU op
            OP_AUIPC: begin
                raw_s.wen      = 1'b1;
                raw_s.op_a_sel = OPA_PC;
                raw_s.op_b_sel = OPB_IMM;
                raw_s.imm      = imm_u_s;
            end
            OP_LUI: begin
                raw_s.wen      = 1'b1;
                raw_s.op_a_sel = OPA_ZERO;
                raw_s.op_b_sel = OPB_IMM;
                raw_s.imm      = imm_u_s;
                raw_s.alu_ctrl = ALU_PASSB;
            end
            default: begin
                raw_s.illegal = 1'b1;
            end
        endcase
        raw_s.illegal = raw_s.illegal | (instr[1:0] != 2'b11);
    end

    // Illegal entries lose every side effect; writes to x0 are dropped
    always_comb begin
        dec           = raw_s;
        dec.wen       = raw_s.wen & ~raw_s.illegal & (raw_s.rd != 5'd0);
        dec.mem_wen   = raw_s.mem_wen & ~raw_s.illegal;
        dec.branch_op = raw_s.branch_op & ~raw_s.illegal;
        dec.jump      = raw_s.jump & ~raw_s.illegal;
    end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: combinational decode into a two-entry MAIN/SKID buffer with a
// registered in_ready so out_ready never reaches the upstream handshake.
module decode_pipe
    import rv_pkg::*;
#(
    parameter int PC_W = 16,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [5:0]      ALU_Control,
    output logic [1:0]      op_A_sel,
    output logic [1:0]      op_B_sel,
    output logic            wEn,
    output logic            mem_wEn,
    output logic            branch_op,
    output logic            jump,
    output logic [1:0]      wb_sel,
    output logic [2:0]      mem_size,
    output logic            illegal
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("decode_pipe: XLEN must be 32");
    end

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b10;

    logic [1:0]      state_r, state_nx_s;
    logic            in_ready_r, out_valid_r;
    logic            push_s, pop_s, load_main_s, main_from_skid_s, load_skid_s;
    decode_t         dec_s, main_r, skid_r;
    logic [PC_W-1:0] main_pc_r, skid_pc_r;

    decode_comb u_decode_comb (
        .instr (in_instr),
        .dec   (dec_s)
    );

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Next buffer state and which entry slots load; flush overrides everything
    always_comb begin
        state_nx_s       = state_r;
        load_main_s      = 1'b0;
        main_from_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nx_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    load_main_s = push_s;
                    state_nx_s  = push_s ? ST_ONE : ST_EMPTY;
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        load_main_s = 1'b1;
                        state_nx_s  = ST_ONE;
                    end else if (push_s) begin
                        load_skid_s = 1'b1;
                        state_nx_s  = ST_TWO;
                    end else if (pop_s) begin
                        state_nx_s  = ST_EMPTY;
                    end else begin
                        state_nx_s  = ST_ONE;
                    end
                end
                ST_TWO: begin
                    main_from_skid_s = pop_s;
                    state_nx_s       = pop_s ? ST_ONE : ST_TWO;
                end
                default: begin
                    state_nx_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Buffer occupancy and the registered handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s != ST_TWO);
            out_valid_r <= (state_nx_s != ST_EMPTY);
        end
    end

    // Entry storage: MAIN refills from the decoder or from SKID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_r    <= '0;
            skid_r    <= '0;
            main_pc_r <= '0;
            skid_pc_r <= '0;
        end else begin
            if (load_main_s) begin
                main_r    <= dec_s;
                main_pc_r <= in_pc;
            end else if (main_from_skid_s) begin
                main_r    <= skid_r;
                main_pc_r <= skid_pc_r;
            end
            if (load_skid_s) begin
                skid_r    <= dec_s;
                skid_pc_r <= in_pc;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_pc      = main_pc_r;
    assign opcode      = main_r.opcode;
    assign rs1         = main_r.rs1;
    assign rs2         = main_r.rs2;
    assign rd          = main_r.rd;
    assign funct3      = main_r.funct3;
    assign funct7      = main_r.funct7;
    assign imm         = XLEN'(main_r.imm);
    assign ALU_Control = main_r.alu_ctrl;
    assign op_A_sel    = main_r.op_a_sel;
    assign op_B_sel    = main_r.op_b_sel;
    assign wEn         = main_r.wen;
    assign mem_wEn     = main_r.mem_wen;
    assign branch_op   = main_r.branch_op;
    assign jump        = main_r.jump;
    assign wb_sel      = main_r.wb_sel;
    assign mem_size    = main_r.mem_size;
    assign illegal     = main_r.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Randomized bench for decode_pipe: a queue-based occupancy model plus an
// instruction-semantics decoder, with directed literal checks on key cases.
module tb_decode_pipe;
    import rv_pkg::*;

    localparam int PC_W = 16;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [PC_W-1:0] in_pc = '0;
    logic [31:0]     in_instr = '0;
    logic            in_ready, out_valid;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      opcode, funct7;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3, mem_size;
    logic [XLEN-1:0] imm;
    logic [5:0]      ALU_Control;
    logic [1:0]      op_A_sel, op_B_sel, wb_sel;
    logic            wEn, mem_wEn, branch_op, jump, illegal;
    logic            run_chk = 1'b0;
    int              n_cmp = 0;
    int              n_bad = 0;

    decode_pipe #(.PC_W(PC_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3),
        .funct7(funct7), .imm(imm), .ALU_Control(ALU_Control), .op_A_sel(op_A_sel),
        .op_B_sel(op_B_sel), .wEn(wEn), .mem_wEn(mem_wEn), .branch_op(branch_op),
        .jump(jump), .wb_sel(wb_sel), .mem_size(mem_size), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } ent_t;

    typedef struct {
        logic [31:0] imm;
        logic [5:0]  alu;
        logic [1:0]  opa, opb, wb;
        logic [2:0]  msz;
        logic        wen, mwen, br, jmp, ill;
    } exp_t;

    localparam logic [5:0] ALU_BY_F3 [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                              ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    localparam logic [6:0] OPS [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                       OP_LOAD, OP_STORE, OP_IMM, OP_REG};

    ent_t mq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // What the instruction means, computed from the ISA field rules
    function automatic exp_t model_dec(input logic [31:0] i);
        exp_t        e;
        logic [31:0] sx;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        w, mw, b, j;
        sx = i[31] ? 32'hFFFF_FFFF : 32'h0;
        f3 = i[14:12];
        f7 = i[31:25];
        e.imm = 32'h0; e.alu = ALU_ADD; e.opa = 2'd0; e.opb = 2'd0; e.wb = 2'd0;
        e.msz = 3'd0; e.ill = (i[1:0] != 2'b11);
        w = 1'b0; mw = 1'b0; b = 1'b0; j = 1'b0;
        case (i[6:0])
            OP_REG: begin
                w = 1'b1;
                e.alu = ALU_BY_F3[f3];
                if (f3 == 3'd0 && f7[5]) e.alu = ALU_SUB;
                if (f3 == 3'd5 && f7[5]) e.alu = ALU_SRA;
                if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) e.ill = 1'b1;
            end
            OP_IMM: begin
                w = 1'b1; e.opb = 2'd1;
                e.imm = 32'($signed(i) >>> 20);
                e.alu = ALU_BY_F3[f3];
                if (f3 == 3'd5 && f7[5]) e.alu = ALU_SRA;
                if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1'b1;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) e.ill = 1'b1;
            end
            OP_LOAD: begin
                w = 1'b1; e.wb = 2'd1; e.opb = 2'd1; e.msz = f3;
                e.imm = 32'($signed(i) >>> 20);
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) e.ill = 1'b1;
            end
            OP_STORE: begin
                mw = 1'b1; e.opb = 2'd1; e.msz = f3;
                e.imm = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
                if (f3 > 3'd2) e.ill = 1'b1;
            end
            OP_BRANCH: begin
                b = 1'b1; e.alu = 6'(f3);
                e.imm = (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
            end
            OP_JAL: begin
                j = 1'b1; w = 1'b1; e.wb = 2'd2; e.opa = 2'd1; e.opb = 2'd1;
                e.imm = (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            end
            OP_JALR: begin
                j = 1'b1; w = 1'b1; e.wb = 2'd2; e.opb = 2'd1;
                e.imm = 32'($signed(i) >>> 20);
                if (f3 != 3'd0) e.ill = 1'b1;
            end
            OP_AUIPC: begin
                w = 1'b1; e.opa = 2'd1; e.opb = 2'd1; e.imm = i & 32'hFFFF_F000;
            end
            OP_LUI: begin
                w = 1'b1; e.opa = 2'd3; e.opb = 2'd1; e.imm = i & 32'hFFFF_F000;
                e.alu = ALU_PASSB;
            end
            default: e.ill = 1'b1;
        endcase
        e.wen  = w && !e.ill && (i[11:7] != 5'd0);
        e.mwen = mw && !e.ill;
        e.br   = b && !e.ill;
        e.jmp  = j && !e.ill;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) r[6:0] = OPS[k];
        k = $urandom_range(0, 3);
        if (k == 0) r[31:25] = 7'h00;
        if (k == 1) r[31:25] = 7'h20;
        return r;
    endfunction

    // Occupancy model: a FIFO of at most two accepted instructions
    always @(posedge clk or posedge rst) begin : model_upd
        bit push;
        if (rst || flush) begin
            mq.delete();
        end else begin
            push = in_valid && (mq.size() < 2);
            if (mq.size() > 0 && out_ready) mq.delete(0);
            if (push) mq.push_back('{pc: in_pc, instr: in_instr});
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin : cmp
        exp_t e;
        if (!rst && run_chk) begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
            if (mq.size() > 0) begin
                e = model_dec(mq[0].instr);
                chk("out_pc", 32'(out_pc), 32'(mq[0].pc));
                chk("opcode", 32'(opcode), 32'(mq[0].instr[6:0]));
                chk("rd", 32'(rd), 32'(mq[0].instr[11:7]));
                chk("funct3", 32'(funct3), 32'(mq[0].instr[14:12]));
                chk("rs1", 32'(rs1), 32'(mq[0].instr[19:15]));
                chk("rs2", 32'(rs2), 32'(mq[0].instr[24:20]));
                chk("funct7", 32'(funct7), 32'(mq[0].instr[31:25]));
                chk("imm", imm, e.imm);
                chk("ALU_Control", 32'(ALU_Control), 32'(e.alu));
                chk("op_A_sel", 32'(op_A_sel), 32'(e.opa));
                chk("op_B_sel", 32'(op_B_sel), 32'(e.opb));
                chk("wb_sel", 32'(wb_sel), 32'(e.wb));
                chk("mem_size", 32'(mem_size), 32'(e.msz));
                chk("wEn", 32'(wEn), 32'(e.wen));
                chk("mem_wEn", 32'(mem_wEn), 32'(e.mwen));
                chk("branch_op", 32'(branch_op), 32'(e.br));
                chk("jump", 32'(jump), 32'(e.jmp));
                chk("illegal", 32'(illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_imm", imm, 32'd0);
        chk("rst_wEn", 32'(wEn), 32'd0);

        // ADDI x1,x0,-1 presented on the very edge after reset release
        rst = 1'b0; run_chk = 1'b1;
        in_valid = 1'b1; in_pc = 16'h0010; in_instr = 32'hFFF0_0093; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_imm", imm, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(rd), 32'd1);
        chk("addi_wEn", 32'(wEn), 32'd1);
        chk("addi_opB", 32'(op_B_sel), 32'd1);
        chk("addi_alu", 32'(ALU_Control), 32'(ALU_ADD));
        @(negedge clk);

        // SW x2,8(x1) then BEQ x1,x2,+16 under a two-cycle stall
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 16'h0020; in_instr = 32'h0020_A423;
        @(negedge clk); in_pc = 16'h0024; in_instr = 32'h0020_8863;
        @(negedge clk); in_valid = 1'b0;
        chk("sw_in_ready", 32'(in_ready), 32'd0);
        chk("sw_mem_wEn", 32'(mem_wEn), 32'd1);
        chk("sw_imm", imm, 32'd8);
        @(negedge clk);
        chk("sw_hold_pc", 32'(out_pc), 32'h0020);
        out_ready = 1'b1;
        @(negedge clk);
        chk("beq_pc", 32'(out_pc), 32'h0024);
        chk("beq_branch", 32'(branch_op), 32'd1);
        chk("beq_imm", imm, 32'd16);
        @(negedge clk);

        // JAL x1,+2048 at 0x0100
        in_valid = 1'b1; in_pc = 16'h0100; in_instr = 32'h0010_00EF;
        @(negedge clk); in_valid = 1'b0;
        chk("jal_jump", 32'(jump), 32'd1);
        chk("jal_wb", 32'(wb_sel), 32'd2);
        chk("jal_imm", imm, 32'h0000_0800);
        chk("jal_pc", 32'(out_pc), 32'h0100);
        @(negedge clk);

        // Unknown opcode, then SUB with funct3=001
        in_valid = 1'b1; in_pc = 16'h0200; in_instr = 32'h0000_707F;
        @(negedge clk); in_instr = 32'h4020_91B3;
        chk("unk_illegal", 32'(illegal), 32'd1);
        chk("unk_valid", 32'(out_valid), 32'd1);
        chk("unk_wEn", 32'(wEn), 32'd0);
        @(negedge clk); in_valid = 1'b0;
        chk("sub_illegal", 32'(illegal), 32'd1);
        chk("sub_enables", 32'({wEn, mem_wEn, branch_op, jump}), 32'd0);
        @(negedge clk);

        // Flush while full with a new instruction offered
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0050_0113;
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("flush_no_stale", 32'(out_valid), 32'd0);

        // ADD x0,x1,x2 must not write
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0020_8033;
        @(negedge clk); in_valid = 1'b0;
        chk("x0_wEn", 32'(wEn), 32'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF0_0093;
        @(negedge clk);
        @(negedge clk); in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_imm", imm, 32'd0);
        chk("arst_opcode", 32'(opcode), 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_pc = 16'h0300; in_instr = 32'h0010_0093; out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_rd", 32'(rd), 32'd1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            in_pc     = 16'($urandom);
            in_instr  = rand_instr();
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
